// File: rtl/rout_uart_tx_if.sv
// Response-byte handshake between the dialogue module and rout_uart_tx.
//   rout_in  : response byte
//   rout_vld : rout_in valid this cycle
//   rout_rdy : UART FIFO can accept a byte (not full)
// master = dialogue module side, slave = UART side.
interface rout_uart_tx_if;
  logic [7:0] rout_in;
  logic       rout_vld;
  logic       rout_rdy;

  modport master (output rout_in, output rout_vld, input rout_rdy);
  modport slave  (input rout_in, input rout_vld, output rout_rdy);
endinterface

// File: rtl/rout_uart_tx.sv
// rout_uart_tx: buffers NLProc response bytes in a small FIFO and sends them
// off-chip as asynchronous serial, 8N1 (LSB first, idle high).
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset; aborts any frame, empties FIFO
//   rif      : rout_uart_tx_if.slave (rout_in, rout_vld, rout_rdy = !full)
//   txd      : serial line, registered, idle high
//   busy     : high while a frame (start..stop) is on the line
//   fifo_cnt : FIFO occupancy 0..FIFO_DEPTH
//   ovf      : sticky; set when a byte is offered while the FIFO is full
//
// Parameters: CLK_DIV (clk cycles per bit, 2..65535), FIFO_DEPTH (power of
// two, 2..256), CNT_W (= log2(FIFO_DEPTH)+1).
//
// Build option: define ROUT_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame grows to 11 bit periods).
module rout_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  rout_uart_tx_if.slave    rif,
  output logic             txd,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             ovf
);
  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);

`ifdef ROUT_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;

  assign full         = (fifo_cnt == FULL_CNT);
  assign empty        = (fifo_cnt == '0);
  assign rif.rout_rdy = !full;
  // Acceptance depends only on registered occupancy, so a byte offered while
  // full is refused even if a pop frees a slot on the same edge.
  assign push         = rif.rout_vld && !full;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rif.rout_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
      if (rif.rout_vld && full) ovf <= 1'b1;
    end
  end

  // ---------------- transmit FSM ----------------
  state_t      state, state_d;
  logic [15:0] baud_cnt, baud_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  shreg, shreg_d;
  logic        txd_d;
  logic        baud_end;
`ifdef ROUT_TX_PARITY_EN
  // Parity is captured at pop time because the shift register consumes
  // the data bits as they go out.
  logic        par, par_d;
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    pop     = 1'b0;
    txd_d   = 1'b1;
`ifdef ROUT_TX_PARITY_EN
    par_d   = par;
`endif
    if (state != S_IDLE) baud_d = baud_end ? 16'd0 : baud_cnt + 16'd1;

    case (state)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        shreg_d = mem[rd_ptr];
        state_d = S_START;
        baud_d  = 16'd0;
`ifdef ROUT_TX_PARITY_EN
        par_d   = ^mem[rd_ptr];
`endif
      end
      S_START: if (baud_end) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
      end
      S_DATA: if (baud_end) begin
        shreg_d = {1'b0, shreg[7:1]};
        if (bit_idx == 3'd7) begin
`ifdef ROUT_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          bit_d = bit_idx + 3'd1;
        end
      end
`ifdef ROUT_TX_PARITY_EN
      S_PARITY: if (baud_end) state_d = S_STOP;
`endif
      S_STOP: if (baud_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line level is derived from the next state so txd can be a flop and
    // still change on the same edge as the state.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
`ifdef ROUT_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
`ifdef ROUT_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shreg    <= shreg_d;
      txd      <= txd_d;
`ifdef ROUT_TX_PARITY_EN
      par      <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_rout_uart_tx.sv
module tb_rout_uart_tx;
  localparam int CD    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
`ifdef ROUT_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = NB * CD;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          txd, busy, ovf;
  logic [CW-1:0] fifo_cnt;

  rout_uart_tx_if rif();

  rout_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rif(rif),
    .txd(txd), .busy(busy), .fifo_cnt(fifo_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame layout: start(0), 8 data bits LSB first, [even parity], stop(1).
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR && b == 9) return ^d;
    return 1'b1;
  endfunction

  // ---------------- reference model / monitor ----------------
  // Occupancy = accepted pushes minus observed frame starts; every byte that
  // goes out must match the oldest accepted byte.
  int         mcnt, pos, cyc, frames_done, peak;
  logic [7:0] mq[$];
  logic [7:0] cur, pend_data;
  bit         in_frame, pend_push, pend_ovf, movf, exp_start, started;
  int         start_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      mcnt = 0; in_frame = 0; pos = 0; movf = 0;
      pend_push = 0; pend_ovf = 0; exp_start = 0;
      chk("rst_txd",  32'(txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt",  32'(fifo_cnt), 32'd0);
      chk("rst_rdy",  32'(rif.rout_rdy), 32'd1);
      chk("rst_ovf",  32'(ovf), 32'd0);
    end else begin
      started = 0;
      if (pend_push) begin mq.push_back(pend_data); mcnt++; end
      if (pend_ovf) movf = 1;
      if (in_frame) begin
        pos++;
        if (pos == FRAME) begin in_frame = 0; frames_done++; end
      end
      if (!in_frame && txd === 1'b0) begin
        chk("start_has_data", 32'(mq.size() > 0), 32'd1);
        if (mq.size() > 0) cur = mq.pop_front(); else cur = 8'h00;
        if (mcnt > 0) mcnt--;
        in_frame = 1; pos = 0; started = 1;
        start_cyc.push_back(cyc);
      end
      if (exp_start) chk("start_latency", 32'(started), 32'd1);
      if (in_frame) chk("txd_bit", 32'(txd), 32'(exp_bit(cur, pos / CD)));
      else          chk("txd_idle", 32'(txd), 32'd1);
      chk("busy",     32'(busy), 32'(in_frame));
      chk("fifo_cnt", 32'(fifo_cnt), 32'(mcnt));
      chk("rout_rdy", 32'(rif.rout_rdy), 32'(mcnt < DEPTH));
      chk("ovf",      32'(ovf), 32'(movf));
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
      exp_start = !in_frame && mcnt > 0;
      pend_push = rif.rout_vld && mcnt < DEPTH;
      pend_data = rif.rout_in;
      pend_ovf  = rif.rout_vld && mcnt == DEPTH;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while ((fifo_cnt != 0 || busy) && n < lim);
    chk(nm, 32'(fifo_cnt == 0 && !busy), 32'd1);
    @(negedge clk); #1;
  endtask

  // Push one byte into an empty, idle UART and check the whole frame.
  task automatic send_frame(input logic [7:0] d, input logic p);
    logic [FRAME-1:0] smp;
    int   w, nbusy;
    logic e;
    @(posedge clk); #1 rif.rout_vld = 1'b1; rif.rout_in = d;
    @(posedge clk); #1 rif.rout_vld = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (txd !== 1'b0 && w < 20);
    chk("tbl_latency", 32'(w), 32'd2);
    nbusy = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      smp[i] = txd;
      nbusy += int'(busy);
    end
    for (int b = 0; b < NB; b++) begin
      if (b == 0)             e = 1'b0;
      else if (b <= 8)        e = d[b-1];
      else if (PAR && b == 9) e = p;
      else                    e = 1'b1;
      chk("tbl_bit", 32'(smp[b*CD +: CD]), 32'({CD{e}}));
    end
    chk("tbl_busy_len", 32'(nbusy), 32'(FRAME));
    @(negedge clk);
    chk("tbl_end_idle", 32'({busy, txd}), 32'd1);
    chk("tbl_end_cnt",  32'(fifo_cnt), 32'd0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       par;   // even parity of din
  } vec_t;

  vec_t vec[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, low, w;
    vec[0] = '{8'hA5, 1'b0};
    vec[1] = '{8'h07, 1'b1};
    vec[2] = '{8'h03, 1'b0};
    vec[3] = '{8'h00, 1'b0};
    vec[4] = '{8'hFF, 1'b0};
    vec[5] = '{8'h80, 1'b1};
    vec[6] = '{8'h3C, 1'b0};
    vec[7] = '{8'h01, 1'b1};

    rif.rout_vld = 1'b0;
    rif.rout_in  = 8'h00;

    // reset + idle
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_txd",  32'(txd), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rdy",  32'(rif.rout_rdy), 32'd1);
    chk("idle_cnt",  32'(fifo_cnt), 32'd0);
    chk("idle_ovf",  32'(ovf), 32'd0);

    // single-byte frames from the table
    foreach (vec[i]) send_frame(vec[i].din, vec[i].par);

    // burst of 5 consecutive pushes
    @(posedge clk); #1;
    start_cyc.delete(); peak = 0; f0 = frames_done;
    for (int i = 1; i <= 5; i++) begin
      rif.rout_vld = 1'b1; rif.rout_in = 8'(i);
      @(posedge clk); #1;
    end
    rif.rout_vld = 1'b0;
    wait_idle(1000, "burst_drain");
    chk("burst_peak",   32'(peak), 32'd4);
    chk("burst_frames", 32'(frames_done - f0), 32'd5);
    chk("burst_starts", 32'(start_cyc.size()), 32'd5);
    for (int i = 1; i < start_cyc.size(); i++)
      chk("burst_spacing", 32'(start_cyc[i] - start_cyc[i-1]), 32'(FRAME + 1));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rif.rout_vld = ($urandom_range(0, 3) == 0);
      rif.rout_in  = 8'($urandom);
    end
    @(posedge clk); #1 rif.rout_vld = 1'b0;
    wait_idle(3000, "rand_drain");

    // overflow: 18 back-to-back pushes
    do_reset();
    @(posedge clk); #1;
    chk("ovf_clear", 32'(ovf), 32'd0);
    f0 = frames_done;
    for (int i = 0; i < 18; i++) begin
      if (i == 17) chk("ovf_rdy_full", 32'(rif.rout_rdy), 32'd0);
      rif.rout_vld = 1'b1; rif.rout_in = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    rif.rout_vld = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    wait_idle(17 * (FRAME + 1) + 100, "ovf_drain");
    chk("ovf_frames", 32'(frames_done - f0), 32'd17);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // reset during data bit 3 of 0x3C with two bytes queued
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      rif.rout_vld = 1'b1;
      rif.rout_in  = (i == 0) ? 8'h3C : (i == 1) ? 8'hAA : 8'h55;
      @(posedge clk); #1;
    end
    rif.rout_vld = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (txd !== 1'b0 && w < 20);
    chk("mid_start_seen", 32'(txd), 32'd0);
    repeat (4 * CD + 1) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    chk("mid_cnt_pre",  32'(fifo_cnt), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_txd",  32'(txd), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cnt",  32'(fifo_cnt), 32'd0);
    chk("mid_rdy",  32'(rif.rout_rdy), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    f0 = frames_done; low = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) low++;
    end
    chk("mid_no_tx",     32'(low), 32'd0);
    chk("mid_no_frames", 32'(frames_done - f0), 32'd0);
    chk("mid_cnt_after", 32'(fifo_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
